// File: rtl/mul_wb_unit.sv
// Iterative 8x8 shift-add multiplier. The 16-bit product goes back to the
// register file as two byte writes through one write port, low byte first.
module mul_wb_unit #(
  parameter int pw = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          sgn,
  input  logic [7:0]    op_a,
  input  logic [7:0]    op_b,
  input  logic [pw-1:0] dst_lo,
  input  logic [pw-1:0] dst_hi,
  output logic          busy,
  output logic          done,
  output logic          wr_en,
  output logic [pw-1:0] wr_addr,
  output logic [7:0]    wr_dat
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_WB_LO = 2'd2;
  localparam logic [1:0] S_WB_HI = 2'd3;

  logic [1:0]        state;
  logic [15:0]       mcand;
  logic [7:0]        mplier;
  logic [15:0]       acc;
  logic [15:0]       acc_next;
  logic [2:0]        cnt;
  logic              neg;
  logic [pw-1:0]     dst_lo_q;
  logic [pw-1:0]     dst_hi_q;
  logic [15:0]       prod;
  logic signed [7:0] a_s;
  logic signed [7:0] b_s;

  // -128 maps to 0x80, which is still the correct unsigned magnitude.
  function automatic logic [7:0] mag8(input logic signed [7:0] v);
    logic [7:0] r;
    r = v[7] ? (~v + 8'd1) : v;
    return r;
  endfunction

  function automatic logic [15:0] apply_sign(input logic [15:0] v, input logic en);
    return en ? (~v + 16'd1) : v;
  endfunction

  assign a_s      = op_a;
  assign b_s      = op_b;
  assign acc_next = acc + (mplier[0] ? mcand : 16'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      dst_lo_q <= '0;
      dst_hi_q <= '0;
      prod     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand    <= {8'd0, (sgn ? mag8(a_s) : op_a)};
            mplier   <= sgn ? mag8(b_s) : op_b;
            neg      <= sgn & (op_a[7] ^ op_b[7]);
            dst_lo_q <= dst_lo;
            dst_hi_q <= dst_hi;
            acc      <= '0;
            cnt      <= '0;
            state    <= S_RUN;
          end
        end
        // one partial product per cycle; product is final on the 8th
        S_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            prod  <= apply_sign(acc_next, neg);
            state <= S_WB_LO;
          end
        end
        S_WB_LO: state <= S_WB_HI;
        S_WB_HI: state <= S_IDLE;
      endcase
    end
  end

  // write-back outputs decode straight from the state register
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_WB_HI);
  assign wr_en   = (state == S_WB_LO) || (state == S_WB_HI);
  assign wr_addr = (state == S_WB_LO) ? dst_lo_q :
                   (state == S_WB_HI) ? dst_hi_q : '0;
  assign wr_dat  = (state == S_WB_LO) ? prod[7:0] :
                   (state == S_WB_HI) ? prod[15:8] : 8'd0;

endmodule
